// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory arbiter.
// Holds the default memory geometry and the FSM/owner encodings used
// by dmem_arbiter and dmem_arb_pick.
package dmem_pkg;
  localparam int DMEM_DEPTH  = 128;
  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 16;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way grant for the data-memory arbiter.
// Ports: a_valid/b_valid requests, en (arbiter idle), grant_a/grant_b one-hot.
// Optional DMEM_ARB_RR_EN: round-robin with an internal pointer flop (adds
// clk/rst); otherwise fixed priority with port A winning.
module dmem_arb_pick
  import dmem_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic a_valid,
  input  logic b_valid,
  input  logic en,
  output logic grant_a,
  output logic grant_b
);

`ifdef DMEM_ARB_RR_EN
  // ptr names the port that has priority on the next tie.
  owner_t ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= OWN_A;
    end else if (grant_a) begin
      ptr <= OWN_B;
    end else if (grant_b) begin
      ptr <= OWN_A;
    end
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      if (a_valid && (!b_valid || ptr == OWN_A)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end
`else
  assign grant_a = en & a_valid;
  assign grant_b = en & b_valid & ~a_valid;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (port A) and the debug/loader port (port B); one registered one-cycle
// strobe per accepted request, registered response one cycle later.
// Ports: a_*/b_* request/response per requester, mem_* memory side.
// Optional DMEM_ARB_RR_EN selects round-robin instead of fixed A priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic                   a_we,
  input  logic [DMEM_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]      a_wdata,
  output logic                   a_ready,
  output logic                   a_resp_valid,
  output logic [DATA_W-1:0]      a_resp_data,
  output logic                   a_resp_err,
  output logic                   a_stall,
  input  logic                   b_valid,
  input  logic                   b_we,
  input  logic [DMEM_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]      b_wdata,
  output logic                   b_ready,
  output logic                   b_resp_valid,
  output logic [DATA_W-1:0]      b_resp_data,
  output logic                   b_resp_err,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  input  logic [DATA_W-1:0]      mem_rdata
);

  // One extra bit so DEPTH up to 2^16 compares cleanly as unsigned.
  localparam logic [DMEM_ADDR_W:0] DEPTH_L = (DMEM_ADDR_W+1)'(DEPTH);

  state_t state, next_state;
  logic   en, grant_a, grant_b, accept;

  logic                   req_we, req_in_range;
  logic [DMEM_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]      req_wdata;

  owner_t                 owner_q;
  logic                   we_q, err_q;
  logic [DMEM_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   mem_we_q, mem_re_q;
  logic                   a_rv_q, b_rv_q, rsp_err_q;
  logic [DATA_W-1:0]      rsp_data_q;

  dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .a_valid (a_valid),
    .b_valid (b_valid),
    .en      (en),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ready is held low while reset is asserted so no grant is visible then.
  always_comb begin
    next_state = state;
    en         = 1'b0;
    case (state)
      IDLE: begin
        en = ~rst;
        if (grant_a || grant_b) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grants are only high with the matching valid, so a grant is an accept.
  assign accept       = grant_a | grant_b;
  assign req_we       = grant_b ? b_we    : a_we;
  assign req_addr     = grant_b ? b_addr  : a_addr;
  assign req_wdata    = grant_b ? b_wdata : a_wdata;
  assign req_in_range = {1'b0, req_addr} < DEPTH_L;

  // Strobes are decided at accept and registered, so they are clean for the
  // whole ACCESS cycle. Address/data regs only move on accept (wdata only on
  // writes) so the memory sees no change outside an access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_A;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      a_rv_q     <= 1'b0;
      b_rv_q     <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      a_rv_q     <= 1'b0;
      b_rv_q     <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      if (accept) begin
        owner_q  <= grant_b ? OWN_B : OWN_A;
        we_q     <= req_we;
        err_q    <= ~req_in_range;
        addr_q   <= req_addr;
        mem_we_q <= req_we & req_in_range;
        mem_re_q <= ~req_we & req_in_range;
        if (req_we) begin
          wdata_q <= req_wdata;
        end
      end
      if (state == ACCESS) begin
        a_rv_q    <= (owner_q == OWN_A);
        b_rv_q    <= (owner_q == OWN_B);
        rsp_err_q <= err_q;
        if (!we_q && !err_q) begin
          rsp_data_q <= mem_rdata;
        end
      end
    end
  end

  assign a_ready      = grant_a;
  assign b_ready      = grant_b;
  assign a_stall      = a_valid & ~grant_a;
  assign a_resp_valid = a_rv_q;
  assign b_resp_valid = b_rv_q;
  assign a_resp_data  = a_rv_q ? rsp_data_q : '0;
  assign b_resp_data  = b_rv_q ? rsp_data_q : '0;
  assign a_resp_err   = a_rv_q & rsp_err_q;
  assign b_resp_err   = b_rv_q & rsp_err_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_we       = mem_we_q;
  assign mem_re       = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic        clk, rst;
  logic        a_valid, a_we, a_ready, a_resp_valid, a_resp_err, a_stall;
  logic [15:0] a_addr, a_wdata, a_resp_data;
  logic        b_valid, b_we, b_ready, b_resp_valid, b_resp_err;
  logic [15:0] b_addr, b_wdata, b_resp_data;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_resp_valid(a_resp_valid), .a_resp_data(a_resp_data),
    .a_resp_err(a_resp_err), .a_stall(a_stall),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_resp_valid(b_resp_valid), .b_resp_data(b_resp_data),
    .b_resp_err(b_resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory: word i preloaded with 16'hBF5A + i; write at edge while mem_we high.
  logic [15:0] mem [0:127];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'hBF5A + 16'(i);
      mem_init <= 1'b1;
    end else if (mem_we && mem_addr < 16'd128) begin
      mem[mem_addr[6:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < 16'd128) ? mem[mem_addr[6:0]] : 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view (accepted request -> strobe next
  // cycle -> response the cycle after), with its own copy of the memory.
  logic [15:0] ref_mem [0:127];
  bit          ref_init = 1'b0;
  bit          cur_v, cur_own, cur_we, rsp_v, rsp_own, rsp_err;
  logic [15:0] cur_addr, cur_wdata, rsp_data, last_addr;
  bit          eg_a, eg_b, idle, cur_in;
`ifdef DMEM_ARB_RR_EN
  bit          ptr_b;
`endif

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = 16'hBF5A + 16'(i);
      ref_init = 1'b1;
    end
    if (rst) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_a_resp_valid", a_resp_valid, 0);
      chk("rst_b_resp_valid", b_resp_valid, 0);
      chk("rst_resp_data", {a_resp_data, b_resp_data}, 0);
      chk("rst_resp_err", {a_resp_err, b_resp_err}, 0);
      chk("rst_strobes", {mem_we, mem_re}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      cur_v = 0; rsp_v = 0; last_addr = 16'h0;
`ifdef DMEM_ARB_RR_EN
      ptr_b = 0;
`endif
    end else begin
      if (mem_we) we_cnt++;
      idle = !cur_v;
`ifdef DMEM_ARB_RR_EN
      eg_a = idle && a_valid && (!b_valid || !ptr_b);
      eg_b = idle && b_valid && (!a_valid || ptr_b);
`else
      eg_a = idle && a_valid;
      eg_b = idle && b_valid && !a_valid;
`endif
      cur_in = cur_addr < 16'd128;
      chk("m_a_ready", a_ready, eg_a);
      chk("m_b_ready", b_ready, eg_b);
      chk("m_a_stall", a_stall, a_valid && !eg_a);
      chk("m_mem_re", mem_re, cur_v && !cur_we && cur_in);
      chk("m_mem_we", mem_we, cur_v && cur_we && cur_in);
      chk("m_mem_addr", mem_addr, cur_v ? cur_addr : last_addr);
      if (cur_v && cur_we && cur_in) chk("m_mem_wdata", mem_wdata, cur_wdata);
      chk("m_a_resp_valid", a_resp_valid, rsp_v && !rsp_own);
      chk("m_b_resp_valid", b_resp_valid, rsp_v && rsp_own);
      chk("m_a_resp_data", a_resp_data, (rsp_v && !rsp_own) ? rsp_data : 16'h0);
      chk("m_b_resp_data", b_resp_data, (rsp_v && rsp_own) ? rsp_data : 16'h0);
      chk("m_a_resp_err", a_resp_err, rsp_v && !rsp_own && rsp_err);
      chk("m_b_resp_err", b_resp_err, rsp_v && rsp_own && rsp_err);
      // Advance one clock edge.
      rsp_v = cur_v; rsp_own = cur_own; rsp_err = cur_v && !cur_in;
      rsp_data = (cur_v && !cur_we && cur_in) ? ref_mem[cur_addr[6:0]] : 16'h0;
      if (cur_v && cur_we && cur_in) ref_mem[cur_addr[6:0]] = cur_wdata;
      cur_v = eg_a || eg_b;
      if (cur_v) begin
        cur_own   = eg_b;
        cur_we    = eg_b ? b_we : a_we;
        cur_addr  = eg_b ? b_addr : a_addr;
        cur_wdata = eg_b ? b_wdata : a_wdata;
        last_addr = cur_addr;
`ifdef DMEM_ARB_RR_EN
        ptr_b = eg_a;
`endif
      end
    end
  end

  task automatic do_req(input bit pb, input bit we, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd, output logic er);
    bit got;
    rd = 16'h0; er = 1'b0; got = 1'b0;
    @(posedge clk); #1;
    if (pb) begin b_valid = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_valid = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = pb ? b_ready : a_ready;
    end
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    chk("req_accepted", got, 1);
    if (!got) return;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (pb ? b_resp_valid : a_resp_valid) begin
        got = 1'b1;
        rd = pb ? b_resp_data : a_resp_data;
        er = pb ? b_resp_err : a_resp_err;
      end
    end
    chk("resp_seen", got, 1);
  endtask

  logic [15:0] d;
  logic        e;
  int          w0, ga, gb, last, alt_ok, rv;

  initial begin
    rst = 1; a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Single load: addr 5 holds 16'hBF5F.
    do_req(0, 0, 16'd5, 16'h0, d, e);
    chk("ld5_data", d, 16'hBF5F);
    chk("ld5_err", e, 0);

    // Write then read back; exactly one write strobe cycle.
    w0 = we_cnt;
    do_req(0, 1, 16'd23, 16'h1234, d, e);
    chk("wr23_ack_data", d, 0);
    chk("wr23_we_cycles", we_cnt - w0, 1);
    do_req(0, 0, 16'd23, 16'h0, d, e);
    chk("rd23_data", d, 16'h1234);

    // Out of range from B, plus the boundary words 127 and 128.
    w0 = we_cnt;
    do_req(1, 0, 16'd200, 16'h0, d, e);
    chk("oor200_err", e, 1);
    chk("oor200_data", d, 0);
    do_req(1, 1, 16'd128, 16'hAAAA, d, e);
    chk("oor128_err", e, 1);
    chk("oor128_no_we", we_cnt - w0, 0);
    do_req(1, 0, 16'd127, 16'h0, d, e);
    chk("b127_data", d, 16'hBFD9);
    chk("b127_err", e, 0);
    do_req(0, 0, 16'hFFFF, 16'h0, d, e);
    chk("oorFFFF_err", e, 1);

    // Contention: both valid for 8 cycles.
    @(posedge clk); #1;
    a_valid = 1; a_we = 0; a_addr = 16'd1;
    b_valid = 1; b_we = 0; b_addr = 16'd2;
    ga = 0; gb = 0; last = 2; alt_ok = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_ready) begin if (last == 0) alt_ok = 0; last = 0; ga++; end
      if (b_ready) begin if (last == 1) alt_ok = 0; last = 1; gb++; end
    end
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
`ifdef DMEM_ARB_RR_EN
    chk("rr_grants_a", ga, 2);
    chk("rr_grants_b", gb, 2);
    chk("rr_alternate", alt_ok, 1);
`else
    chk("fixed_grants_a", ga, 4);
    chk("fixed_grants_b", gb, 0);
`endif
    repeat (3) @(posedge clk);

    // Stall: A waits while B owns the access.
    @(posedge clk); #1;
    b_valid = 1; b_we = 0; b_addr = 16'd7;
    @(negedge clk);
    chk("stall_b_ready", b_ready, 1);
    @(posedge clk); #1;
    b_valid = 0; a_valid = 1; a_we = 0; a_addr = 16'd9;
    @(negedge clk);
    chk("stall_a_ready_busy", a_ready, 0);
    chk("stall_a_stall_busy", a_stall, 1);
    @(negedge clk);
    chk("stall_a_ready_idle", a_ready, 1);
    chk("stall_a_stall_idle", a_stall, 0);
    chk("stall_b_resp", b_resp_valid, 1);
    chk("stall_b_data", b_resp_data, 16'hBF61);
    @(posedge clk); #1;
    a_valid = 0;
    repeat (3) @(posedge clk);

    // Reset during the write strobe cycle.
    @(posedge clk); #1;
    a_valid = 1; a_we = 1; a_addr = 16'd40; a_wdata = 16'hDEAD;
    @(negedge clk);
    chk("rst_mid_ready", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 0;
    chk("rst_mid_we_before", mem_we, 1);
    rst = 1; #1;
    chk("rst_mid_we_drop", mem_we, 0);
    @(posedge clk); #1 rst = 0;
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_resp_valid || b_resp_valid) rv = 1;
    end
    chk("rst_mid_no_resp", rv, 0);
    do_req(0, 0, 16'd40, 16'h0, d, e);
    chk("rst_mid_data_kept", d, 16'hBF82);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
